// File: rtl/bsg_expand_bitmask_serial.sv
// bsg_expand_bitmask_serial
// Accepts an in_width_p-bit mask, replicates each bit expand_p times and
// streams the expanded vector out LSB-first as els_p beats of beat_width
// bits, one beat per cycle under a valid/yumi handshake.
// Optional build macro: BSG_EXPAND_BITMASK_ZERO_SKIP_EN
//   When defined, all-zero beats are skipped. An all-zero mask still emits
//   one beat (idx 0, data 0, last 1).
//
// state | meaning
// IDLE  | no mask held; ready_o=1, v_o=0
// SEND  | presenting beat idx_q of mask_q; v_o=1

module bsg_expand_bitmask_serial #(
   parameter int in_width_p = 4,
   parameter int expand_p   = 2,
   parameter int els_p      = 2,
   localparam int beat_width_lp = in_width_p * expand_p / els_p,
   localparam int idx_width_lp  = (els_p > 1) ? $clog2(els_p) : 1
) (
   input  logic                     clk_i,
   input  logic                     reset_i,
   input  logic                     v_i,
   input  logic [in_width_p-1:0]    data_i,
   output logic                     ready_o,
   output logic                     v_o,
   output logic [beat_width_lp-1:0] data_o,
   output logic [idx_width_lp-1:0]  idx_o,
   output logic                     last_o,
   input  logic                     yumi_i
);

   localparam int full_width_lp = in_width_p * expand_p;
   localparam logic [idx_width_lp-1:0] last_idx_lp = idx_width_lp'(els_p - 1);

   if (in_width_p % els_p != 0) begin : g_bad_params
      $error("bsg_expand_bitmask_serial: in_width_p must be a multiple of els_p");
   end

   typedef enum logic {
      IDLE = 1'b0,
      SEND = 1'b1
   } state_e;

   state_e                    state_q, state_d;
   logic [in_width_p-1:0]     mask_q, mask_d;
   logic [idx_width_lp-1:0]   idx_q, idx_d;
   logic [full_width_lp-1:0]  expanded;
   logic [beat_width_lp-1:0]  beat;
   logic                      last_beat;
   logic [idx_width_lp-1:0]   next_idx;
   logic [idx_width_lp-1:0]   load_idx;
   logic                      load;

   function automatic logic [full_width_lp-1:0] expand(input logic [in_width_p-1:0] m);
      logic [full_width_lp-1:0] e;
      e = '0;
      for (int k = 0; k < full_width_lp; k++) begin
         e[k] = m[k / expand_p];
      end
      return e;
   endfunction

   assign expanded = expand(mask_q);
   assign beat     = expanded[int'(idx_q) * beat_width_lp +: beat_width_lp];

`ifdef BSG_EXPAND_BITMASK_ZERO_SKIP_EN
   function automatic logic [els_p-1:0] beat_nz(input logic [in_width_p-1:0] m);
      logic [full_width_lp-1:0] e;
      logic [els_p-1:0]         nz;
      e  = expand(m);
      nz = '0;
      for (int n = 0; n < els_p; n++) begin
         nz[n] = |e[n * beat_width_lp +: beat_width_lp];
      end
      return nz;
   endfunction

   logic [els_p-1:0] nz_cur;
   logic [els_p-1:0] nz_in;

   assign nz_cur = beat_nz(mask_q);
   assign nz_in  = beat_nz(data_i);

   // Find the next nonzero beat above idx_q, and the first nonzero beat of a new mask.
   always_comb begin
      last_beat = 1'b1;
      next_idx  = idx_q;
      load_idx  = '0;
      for (int n = els_p - 1; n >= 0; n--) begin
         if (nz_cur[n] && (n > int'(idx_q))) begin
            last_beat = 1'b0;
            next_idx  = idx_width_lp'(n);
         end
         if (nz_in[n]) begin
            load_idx = idx_width_lp'(n);
         end
      end
   end
`else
   // Every beat is sent; the last one is simply the highest index.
   always_comb begin
      last_beat = (idx_q == last_idx_lp);
      next_idx  = idx_q + 1'b1;
      load_idx  = '0;
   end
`endif

   // State and datapath registers.
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
         mask_q  <= '0;
         idx_q   <= '0;
      end else begin
         state_q <= state_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
      end
   end

   // Next-state: load on acceptance, advance on yumi, drop to IDLE after the last beat.
   always_comb begin
      state_d = state_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      load    = 1'b0;
      case (state_q)
         IDLE: begin
            load = v_i;
         end
         SEND: begin
            if (yumi_i) begin
               if (last_beat) begin
                  if (v_i) begin
                     load = 1'b1;
                  end else begin
                     state_d = IDLE;
                     idx_d   = '0;
                  end
               end else begin
                  idx_d = next_idx;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (load) begin
         state_d = SEND;
         mask_d  = data_i;
         idx_d   = load_idx;
      end
   end

   // Outputs: beat fields come only from registers; ready_o is the one path from yumi_i.
   always_comb begin
      ready_o = 1'b1;
      v_o     = 1'b0;
      data_o  = '0;
      idx_o   = '0;
      last_o  = 1'b0;
      if (!reset_i && (state_q == SEND)) begin
         v_o     = 1'b1;
         data_o  = beat;
         idx_o   = idx_q;
         last_o  = last_beat;
         ready_o = yumi_i & last_beat;
      end
   end

endmodule

// File: doc/bsg_expand_bitmask_serial.md
BSG_EXPAND_BITMASK_SERIAL -- requirements
Module: bsg_expand_bitmask_serial

Interface
REQ-001: Parameter in_width_p, default 4: input mask width in bits.
REQ-002: Parameter expand_p, default 2: replication factor per mask bit.
REQ-003: Parameter els_p, default 2: output beats per mask; in_width_p % els_p == 0, elaboration error otherwise.
REQ-004: Derived values: beat_width = in_width_p*expand_p/els_p; idx_width = max(1, clog2(els_p)).
REQ-005: Port clk_i  input  1  sole clock; rising edge.
REQ-006: Port reset_i  input  1  synchronous, active-high reset.
REQ-007: Port v_i  input  1  input mask valid.
REQ-008: Port data_i  input  in_width_p  input bitmask.
REQ-009: Port ready_o  output  1  block accepts data_i this cycle.
REQ-010: Port v_o  output  1  output beat valid.
REQ-011: Port data_o  output  beat_width  current expanded beat.
REQ-012: Port idx_o  output  idx_width  index of current beat.
REQ-013: Port last_o  output  1  current beat is the final beat of the mask.
REQ-014: Port yumi_i  input  1  consumer takes the beat; legal only when v_o=1.

Function
REQ-015: Expansion: expanded bit k = mask bit floor(k/expand_p), for k in 0..in_width_p*expand_p-1.
REQ-016: Beat n: data_o = expanded[(n+1)*beat_width-1 : n*beat_width]; beats are sent LSB-first.
REQ-017: FSM has two states: IDLE and SEND.
REQ-018: IDLE: ready_o=1, v_o=0; v_i=1 registers data_i into the mask register, sets idx=0, and moves to SEND.
REQ-019: SEND: v_o=1, data_o/idx_o/last_o come from registers and the current idx, with no combinational path from v_i or data_i.
REQ-020: SEND with yumi_i=1 and last_o=0: idx increments and the state stays SEND.
REQ-021: SEND with yumi_i=1 and last_o=1: ready_o=1 in the same cycle.
  - if v_i=1: the new mask is loaded, idx=0, state stays SEND; back-to-back masks have no bubble.
  - else: state goes to IDLE.
REQ-022: SEND with yumi_i=0: all state and outputs hold; data_o is stable while v_o=1.
REQ-023: In SEND, ready_o = yumi_i & last_o, the only combinational input-to-output path.
REQ-024: els_p=1: every beat is last; idx_o is constantly 0.
REQ-025: Latency: the first beat is valid the cycle after acceptance; sustained throughput is one beat per cycle.
REQ-026: v_i and data_i are ignored whenever ready_o=0.

Reset
REQ-027: reset_i=1 at a clock edge forces IDLE and idx=0, clears the mask register, and discards any beat in flight.
REQ-028: While reset_i=1, and in the cycle after it: v_o=0, ready_o=1, data_o=0, idx_o=0, last_o=0.

Configuration
REQ-029: Macro BSG_EXPAND_BITMASK_ZERO_SKIP_EN, when defined, makes SEND skip beats whose expanded slice is all zero.
  - idx advances to the next nonzero beat.
  - last_o=1 on the final nonzero beat.
  - an all-zero mask emits exactly one beat: idx_o=0, data_o=0, last_o=1.
  - after acceptance, the first beat presented is the lowest nonzero beat.
REQ-030: Without the macro, all els_p beats are always emitted, per REQ-020 and REQ-021.

Verification (defaults in_width_p=4, expand_p=2, els_p=2, beat_width=4)
REQ-031: Reset, then data_i=4'b0110 with v_i=1 and yumi_i=1 held -> beat0 data_o=4'b1100, idx_o=0, last_o=0; next cycle data_o=4'b0011, idx_o=1, last_o=1.
REQ-032: Masks 4'b0110 then 4'b1001 back-to-back with yumi_i=1 -> ready_o=1 on the last beat of the first mask; four consecutive beats 1100, 0011, 0011, 1100 with no bubble.
REQ-033: data_i=4'b1111 with yumi_i=0 for 3 cycles -> v_o=1, data_o=4'b1111, idx_o=0 held; ready_o=0; a v_i pulse in that window is ignored.
REQ-034: reset_i asserted after beat0 of 4'b0110 is taken -> next cycle v_o=0, ready_o=1, idx_o=0, and no beat1 is emitted.
REQ-035: ZERO_SKIP_EN, data_i=4'b1100 -> single beat data_o=4'b1111, idx_o=1, last_o=1; data_i=4'b0000 -> single beat data_o=0, idx_o=0, last_o=1.
REQ-036: Without ZERO_SKIP_EN, data_i=4'b0000 -> two beats of data_o=0, with last_o=1 on idx_o=1.
